// File: rtl/fl_alloc_ctrl_if.sv
// Bundle between dispatch/ROB/free list and the allocation controller.
// master: the environment (dispatch, ROB, free list); slave: fl_alloc_ctrl.
interface fl_alloc_ctrl_if #(
  parameter int unsigned TAG_W = 7
);
  // Dispatch / ROB requests
  logic [1:0]       id_req_num;
  logic [1:0]       rob_retire_num;
  logic [TAG_W-1:0] rob_retire_tag_0;
  logic [TAG_W-1:0] rob_retire_tag_1;
  logic             rob_mispredict;
  logic [1:0]       rob_squash_num;
  logic [TAG_W-1:0] rob_squash_tag_0;
  logic [TAG_W-1:0] rob_squash_tag_1;
  logic             rob_squash_done;

  // Controller decisions and status
  logic [1:0]       fl_dispatch_num;
  logic [1:0]       fl_retire_num;
  logic [TAG_W-1:0] fl_retire_tag_0;
  logic [TAG_W-1:0] fl_retire_tag_1;
  logic             id_stall;
  logic             rob_retire_hold;
  logic [6:0]       free_count;
  logic             recovering;
  logic             fl_err;

  modport master (
    output id_req_num, rob_retire_num, rob_retire_tag_0, rob_retire_tag_1, rob_mispredict,
           rob_squash_num, rob_squash_tag_0, rob_squash_tag_1, rob_squash_done,
    input  fl_dispatch_num, fl_retire_num, fl_retire_tag_0, fl_retire_tag_1, id_stall,
           rob_retire_hold, free_count, recovering, fl_err
  );

  modport slave (
    input  id_req_num, rob_retire_num, rob_retire_tag_0, rob_retire_tag_1, rob_mispredict,
           rob_squash_num, rob_squash_tag_0, rob_squash_tag_1, rob_squash_done,
    output fl_dispatch_num, fl_retire_num, fl_retire_tag_0, fl_retire_tag_1, id_stall,
           rob_retire_hold, free_count, recovering, fl_err
  );
endinterface

// File: rtl/fl_alloc_ctrl.sv
// Physical-register allocation controller: dispatch grant, release-port mux, exact free
// count and RUN/RECOVER sequencing for mispredict tag reclamation.
module fl_alloc_ctrl #(
  parameter int unsigned NUM_PR = 64,
  parameter int unsigned TAG_W  = 7
) (
  input logic            clock,
  input logic            reset,
  fl_alloc_ctrl_if.slave bus
);

  typedef enum logic [0:0] {StRun, StRecover} state_e;

  state_e     state_q, state_d;
  logic [6:0] free_count_q, free_count_d;
  logic       fl_err_q, fl_err_d;

  logic [1:0] req_n, ret_n, sq_n;
  logic       illegal;
  logic [1:0] grant;
  logic [1:0] rel;
  logic [7:0] avail;
  logic [7:0] total;
  logic [7:0] diff;

  // A count of 3 is out of range; treat it as 2.
  function automatic logic [1:0] clip2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd2 : v;
  endfunction

  // Sanitise request counts and compute the grant from forwarded availability.
  always_comb begin
    req_n   = clip2(bus.id_req_num);
    ret_n   = clip2(bus.rob_retire_num);
    sq_n    = clip2(bus.rob_squash_num);
    illegal = (bus.id_req_num == 2'd3) || (bus.rob_retire_num == 2'd3) ||
              (bus.rob_squash_num == 2'd3);
    // Same-cycle retirements are forwarded by the free list, so they count as available.
    avail   = {1'b0, free_count_q} + {6'b0, ret_n};
    grant   = 2'd0;
    rel     = 2'd0;
    if (state_q == StRun) begin
      rel   = ret_n;
      // In-order service: a partial grant can only be slot 0.
      grant = ({6'b0, req_n} <= avail) ? req_n : avail[1:0];
    end else begin
      rel   = sq_n;
    end
  end

  // Drive free-list ports and handshake outputs; everything is parked while in reset.
  always_comb begin
    bus.fl_dispatch_num = 2'd0;
    bus.fl_retire_num   = 2'd0;
    bus.fl_retire_tag_0 = '0;
    bus.fl_retire_tag_1 = '0;
    bus.id_stall        = 1'b1;
    bus.rob_retire_hold = 1'b0;
    if (reset) begin
      bus.fl_dispatch_num = grant;
      bus.fl_retire_num   = rel;
      if (state_q == StRun) begin
        bus.fl_retire_tag_0 = bus.rob_retire_tag_0;
        bus.fl_retire_tag_1 = bus.rob_retire_tag_1;
        bus.id_stall        = (grant < req_n);
      end else begin
        bus.fl_retire_tag_0 = bus.rob_squash_tag_0;
        bus.fl_retire_tag_1 = bus.rob_squash_tag_1;
        bus.rob_retire_hold = 1'b1;
      end
    end
  end

  // Next free count with saturation, sticky error and FSM transition.
  always_comb begin
    fl_err_d     = fl_err_q | illegal;
    total        = {1'b0, free_count_q} + {6'b0, rel};
    diff         = 8'd0;
    free_count_d = free_count_q;
    if (total < {6'b0, grant}) begin
      fl_err_d     = 1'b1;
      free_count_d = 7'd0;
    end else begin
      diff = total - {6'b0, grant};
      if (diff > 8'(NUM_PR)) begin
        fl_err_d     = 1'b1;
        free_count_d = 7'(NUM_PR);
      end else begin
        free_count_d = diff[6:0];
      end
    end

    state_d = state_q;
    unique case (state_q)
      StRun:     if (bus.rob_mispredict)  state_d = StRecover;
      StRecover: if (bus.rob_squash_done) state_d = StRun;
      default:   state_d = StRun;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StRun;
      free_count_q <= 7'(NUM_PR);
      fl_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      free_count_q <= free_count_d;
      fl_err_q     <= fl_err_d;
    end
  end

  assign bus.free_count = free_count_q;
  assign bus.recovering = (state_q == StRecover);
  assign bus.fl_err     = fl_err_q;

endmodule

// File: tb/tb_fl_alloc_ctrl.sv
// Bench for fl_alloc_ctrl: directed boundary scenarios plus randomized traffic against a
// count/state reference model.
module tb_fl_alloc_ctrl;
  localparam int unsigned NUM_PR = 64;
  localparam int unsigned TAG_W  = 7;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fl_alloc_ctrl_if #(.TAG_W(TAG_W)) bus ();

  fl_alloc_ctrl #(.NUM_PR(NUM_PR), .TAG_W(TAG_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_fc;
  bit m_rec;
  bit m_err;
  bit m_valid = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clip(input int v);
    return (v == 3) ? 2 : v;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic idle();
    bus.id_req_num       = 2'd0;
    bus.rob_retire_num   = 2'd0;
    bus.rob_retire_tag_0 = '0;
    bus.rob_retire_tag_1 = '0;
    bus.rob_mispredict   = 1'b0;
    bus.rob_squash_num   = 2'd0;
    bus.rob_squash_tag_0 = '0;
    bus.rob_squash_tag_1 = '0;
    bus.rob_squash_done  = 1'b0;
  endtask

  // Compare every output against the model, mid-cycle.
  task automatic eval();
    int req, ret, sq, g, rn, t0, t1, stall, hold;
    @(negedge clock);
    req = clip(int'(bus.id_req_num));
    ret = clip(int'(bus.rob_retire_num));
    sq  = clip(int'(bus.rob_squash_num));
    if (!reset) begin
      g = 0; rn = 0; t0 = 0; t1 = 0; stall = 1; hold = 0;
    end else if (m_rec) begin
      g = 0; rn = sq; stall = 1; hold = 1;
      t0 = int'(bus.rob_squash_tag_0);
      t1 = int'(bus.rob_squash_tag_1);
    end else begin
      g = imin(req, m_fc + ret);
      rn = ret; stall = (g < req) ? 1 : 0; hold = 0;
      t0 = int'(bus.rob_retire_tag_0);
      t1 = int'(bus.rob_retire_tag_1);
    end
    check_val("grant", 32'(bus.fl_dispatch_num), 32'(g));
    check_val("rel_num", 32'(bus.fl_retire_num), 32'(rn));
    check_val("rel_tag0", 32'(bus.fl_retire_tag_0), 32'(t0));
    check_val("rel_tag1", 32'(bus.fl_retire_tag_1), 32'(t1));
    check_val("stall", 32'(bus.id_stall), 32'(stall));
    check_val("hold", 32'(bus.rob_retire_hold), 32'(hold));
    if (m_valid) begin
      check_val("free_count", 32'(bus.free_count), 32'(m_fc));
      check_val("recovering", 32'(bus.recovering), 32'(m_rec));
      check_val("fl_err", 32'(bus.fl_err), 32'(m_err));
    end
  endtask

  // Clock edge: advance the model from the inputs held across it.
  task automatic adv();
    int req, ret, sq, g, rel, nf;
    @(posedge clock);
    if (!reset) begin
      m_fc = NUM_PR; m_rec = 1'b0; m_err = 1'b0; m_valid = 1'b1;
    end else begin
      if (bus.id_req_num == 2'd3 || bus.rob_retire_num == 2'd3 || bus.rob_squash_num == 2'd3)
        m_err = 1'b1;
      req = clip(int'(bus.id_req_num));
      ret = clip(int'(bus.rob_retire_num));
      sq  = clip(int'(bus.rob_squash_num));
      rel = m_rec ? sq : ret;
      g   = m_rec ? 0 : imin(req, m_fc + ret);
      nf  = m_fc + rel - g;
      if (nf > int'(NUM_PR)) begin m_err = 1'b1; nf = NUM_PR; end
      if (nf < 0) begin m_err = 1'b1; nf = 0; end
      m_fc = nf;
      if (!m_rec && bus.rob_mispredict) m_rec = 1'b1;
      else if (m_rec && bus.rob_squash_done) m_rec = 1'b0;
    end
    #1;
  endtask

  task automatic cyc();
    eval();
    adv();
  endtask

  // Walk the free count to a target through normal RUN traffic.
  task automatic set_count(input int target);
    for (int i = 0; i < 200 && m_fc != target; i++) begin
      idle();
      if (m_fc > target) bus.id_req_num = 2'(imin(2, m_fc - target));
      else begin
        bus.rob_retire_num   = 2'(imin(2, target - m_fc));
        bus.rob_retire_tag_0 = 7'($urandom_range(0, 127));
        bus.rob_retire_tag_1 = 7'($urandom_range(0, 127));
      end
      cyc();
    end
    check_val("set_count", 32'(m_fc), 32'(target));
  endtask

  initial begin
    idle();
    // Reset release
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    check_val("rst_fc", 32'(bus.free_count), 32'd64);
    check_val("rst_rec", 32'(bus.recovering), 32'd0);
    check_val("rst_err", 32'(bus.fl_err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      bus.id_req_num = 2'd2;
      eval();
      check_val("init_grant", 32'(bus.fl_dispatch_num), 32'd2);
      adv();
      check_val("init_fc", 32'(bus.free_count), 32'(62 - 2 * i));
    end

    // Exhaustion
    set_count(1);
    idle();
    bus.id_req_num = 2'd2;
    eval();
    check_val("exh1_grant", 32'(bus.fl_dispatch_num), 32'd1);
    check_val("exh1_stall", 32'(bus.id_stall), 32'd1);
    adv();
    check_val("exh1_fc", 32'(bus.free_count), 32'd0);
    bus.rob_retire_num = 2'd1;
    bus.rob_retire_tag_0 = 7'd5;
    eval();
    check_val("exh2_grant", 32'(bus.fl_dispatch_num), 32'd1);
    check_val("exh2_stall", 32'(bus.id_stall), 32'd1);
    adv();
    check_val("exh2_fc", 32'(bus.free_count), 32'd0);
    idle();
    bus.id_req_num = 2'd2;
    eval();
    check_val("exh3_grant", 32'(bus.fl_dispatch_num), 32'd0);
    adv();

    // Forwarding
    set_count(10);
    idle();
    bus.id_req_num = 2'd2;
    bus.rob_retire_num = 2'd2;
    bus.rob_retire_tag_0 = 7'd40;
    bus.rob_retire_tag_1 = 7'd41;
    eval();
    check_val("fwd_grant", 32'(bus.fl_dispatch_num), 32'd2);
    check_val("fwd_tag0", 32'(bus.fl_retire_tag_0), 32'd40);
    check_val("fwd_tag1", 32'(bus.fl_retire_tag_1), 32'd41);
    adv();
    check_val("fwd_fc", 32'(bus.free_count), 32'd10);

    // Recovery
    set_count(20);
    idle();
    bus.rob_mispredict = 1'b1;
    bus.id_req_num = 2'd1;
    eval();
    check_val("mis_grant", 32'(bus.fl_dispatch_num), 32'd1);
    adv();
    check_val("mis_fc", 32'(bus.free_count), 32'd19);
    check_val("mis_rec", 32'(bus.recovering), 32'd1);
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.id_req_num = 2'd2;
      bus.rob_squash_num = (i == 2) ? 2'd1 : 2'd2;
      bus.rob_squash_tag_0 = 7'(60 + 2 * i);
      bus.rob_squash_tag_1 = 7'(61 + 2 * i);
      bus.rob_squash_done = (i == 2);
      bus.rob_mispredict = (i == 0);
      eval();
      check_val("sq_num", 32'(bus.fl_retire_num), (i == 2) ? 32'd1 : 32'd2);
      check_val("sq_hold", 32'(bus.rob_retire_hold), 32'd1);
      check_val("sq_grant", 32'(bus.fl_dispatch_num), 32'd0);
      adv();
    end
    check_val("rec_fc", 32'(bus.free_count), 32'd24);
    check_val("rec_done", 32'(bus.recovering), 32'd0);
    idle();
    bus.id_req_num = 2'd2;
    eval();
    check_val("post_rec_grant", 32'(bus.fl_dispatch_num), 32'd2);
    adv();

    // Reset mid-RECOVER
    idle();
    bus.rob_mispredict = 1'b1;
    cyc();
    idle();
    bus.rob_squash_num = 2'd2;
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    check_val("rstrec_fc", 32'(bus.free_count), 32'd64);
    check_val("rstrec_rec", 32'(bus.recovering), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      idle();
      bus.id_req_num       = 2'($urandom_range(0, 2));
      bus.rob_retire_tag_0 = 7'($urandom_range(0, 127));
      bus.rob_retire_tag_1 = 7'($urandom_range(0, 127));
      bus.rob_squash_tag_0 = 7'($urandom_range(0, 127));
      bus.rob_squash_tag_1 = 7'($urandom_range(0, 127));
      bus.rob_mispredict   = ($urandom_range(0, 15) == 0);
      bus.rob_squash_done  = ($urandom_range(0, 3) == 0);
      bus.rob_retire_num   = 2'($urandom_range(0, 1));
      bus.rob_squash_num   = 2'($urandom_range(0, 2));
      if (m_rec) bus.rob_squash_num = 2'(imin(int'(bus.rob_squash_num), NUM_PR - m_fc));
      else bus.rob_retire_num = 2'(imin(int'(bus.rob_retire_num), NUM_PR - m_fc));
      reset = ($urandom_range(0, 299) != 0);
      cyc();
    end
    reset = 1'b1;

    // Error: overflow at full count, then illegal request
    idle();
    bus.rob_squash_done = 1'b1;
    cyc();
    cyc();
    set_count(64);
    idle();
    bus.rob_retire_num = 2'd1;
    bus.rob_retire_tag_0 = 7'd9;
    cyc();
    check_val("ovf_err", 32'(bus.fl_err), 32'd1);
    check_val("ovf_fc", 32'(bus.free_count), 32'd64);
    idle();
    repeat (3) cyc();
    check_val("err_sticky", 32'(bus.fl_err), 32'd1);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    check_val("err_clr", 32'(bus.fl_err), 32'd0);
    bus.id_req_num = 2'd3;
    eval();
    check_val("ill_grant", 32'(bus.fl_dispatch_num), 32'd2);
    check_val("ill_stall", 32'(bus.id_stall), 32'd0);
    adv();
    check_val("ill_err", 32'(bus.fl_err), 32'd1);
    check_val("ill_fc", 32'(bus.free_count), 32'd62);
    idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fl_alloc_ctrl.md
# fl_alloc_ctrl

Allocation controller that sits between dispatch, the ROB and the physical-register free list. Each cycle it decides how many destination registers the free list hands out, based on the dispatch request and the number of physical tags actually available. It also decides which source, ROB retirement or mispredict squash, drives the free list's two release ports. It keeps an exact count of free physical registers (0..64) and sequences a RUN/RECOVER state machine for branch-mispredict tag reclamation.

## Interface
Parameters:
- NUM_PR, 64: number of renamable physical registers; also the reset value of the free count.
- TAG_W, 7: physical tag width.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low (asserted when 0, sampled on posedge clock).
- id_req_num  in  2  destination registers requested by dispatch this cycle, 0..2.
- rob_retire_num  in  2  tags released by ROB retirement, 0..2.
- rob_retire_tag_0, rob_retire_tag_1  in  TAG_W  retired tags; tag_0 valid if num≥1.
- rob_mispredict  in  1  one-cycle pulse; starts recovery.
- rob_squash_num  in  2  squashed-entry tags released this cycle, 0..2; meaningful only in RECOVER.
- rob_squash_tag_0, rob_squash_tag_1  in  TAG_W  squashed tags.
- rob_squash_done  in  1  last squash beat; may coincide with nonzero rob_squash_num.
- fl_dispatch_num  out  2  grant to free list, 0..2 (combinational).
- fl_retire_num  out  2  release count driven to free list (combinational).
- fl_retire_tag_0, fl_retire_tag_1  out  TAG_W  release tags driven to free list.
- id_stall  out  1  dispatch must hold its unserved request.
- rob_retire_hold  out  1  ROB must not retire (high in RECOVER).
- free_count  out  7  registered free-register count.
- recovering  out  1  state == RECOVER.
- fl_err  out  1  sticky; count underflow/overflow or illegal input seen.

## Operation
- States: RUN (reset state) and RECOVER.
- RUN:
  - Release mux passes ROB retire inputs: fl_retire_num = rob_retire_num, tags likewise.
  - avail = free_count + rob_retire_num. The free list forwards same-cycle releases, so released tags count as available.
  - Grant = min(id_req_num, avail). Requests are served in order, so a partial grant is always 1 (slot 0).
  - id_stall = (grant < id_req_num).
  - rob_mispredict moves the FSM to RECOVER next cycle. The same-cycle grant and retire are still honoured; the younger dispatch is squashed by the ROB, not by this block.
- RECOVER:
  - fl_dispatch_num = 0, id_stall = 1, rob_retire_hold = 1.
  - Release mux passes the squash inputs: fl_retire_num = rob_squash_num, tags likewise.
  - rob_squash_done returns the FSM to RUN next cycle; the squash beat in that same cycle is still counted.
  - rob_mispredict while in RECOVER is ignored.
- Count update every non-reset cycle: free_count_next = free_count + released − granted. Width is 8-bit internally.
- If the result is >NUM_PR or <0: set fl_err, and saturate free_count to NUM_PR or 0 respectively.
- Illegal inputs: any of the 2-bit inputs equal to 3 is treated as 2 and sets fl_err.
- Reset (any cycle, including mid-RECOVER): free_count = 64, state = RUN, fl_err = 0. While reset is asserted, all combinational outputs are forced to 0 and id_stall = 1.

## Timing
- Grant, stall and the release mux are combinational from inputs and current state: zero latency, same cycle as the free list consumes them.
- free_count, recovering and fl_err reflect a cycle's events on the following cycle.
- RECOVER lasts at least one cycle. Mispredict in cycle N puts the FSM in RECOVER at N+1. Squash_done at cycle M returns it to RUN at M+1, and dispatch may be granted in M+1.
- Boundaries:
  - free_count = 0 with req 2 and retire 1: grant 1, stall 1.
  - free_count = 0 with req 2 and retire 0: grant 0, stall 1.
  - free_count = 64 with retire 1 and req 0: fl_err set, count held at 64.

## Test plan
- Reset release: drive reset=0 for 2 cycles, then 1. Required: free_count = 64, recovering = 0, fl_err = 0. Then req 2 for 3 cycles gives grant 2 each cycle and free_count 62, 60, 58.
- Exhaustion: with free_count = 1, drive req 2, retire 0. Required: grant 1, id_stall 1, next count 0. With count 0, drive req 2, retire 1. Required: grant 1, stall 1, count stays 0.
- Forwarding: with count 10, drive req 2, retire 2 with tags 40/41. Required: grant 2, fl_retire_tag_0/1 = 40/41, count stays 10.
- Recovery: with count 20, drive mispredict with req 1. Required: grant 1, count 19. Then squash 2, 2, 1+done. Required: fl_retire_num follows 2, 2, 1; rob_retire_hold = 1 throughout; dispatch grant 0 throughout; count reaches 24, then RUN the next cycle.
- Reset mid-RECOVER: assert reset during a squash beat. Required: next cycle state RUN, count 64, squash beat not counted.
- Error: with count 64, drive retire 1; separately drive id_req_num = 3. Required: fl_err rises and stays high until reset; count held at 64 in the first case, and the request is treated as 2 in the second.
